// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM port between NUM_REQ masters, with burst lock,
// a hold-time fairness limit and per-master read-data-valid tagging.
module sram_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_i,
  input  logic [NUM_REQ-1:0]     lock_i,
  input  logic [NUM_REQ-1:0]     ce_i,
  input  logic [NUM_REQ-1:0]     we_i,
  input  logic [NUM_REQ*32-1:0]  addr_i,
  input  logic [NUM_REQ*4-1:0]   sel_i,
  input  logic [NUM_REQ*32-1:0]  wdata_i,
  output logic [NUM_REQ-1:0]     gnt_o,
  output logic [NUM_REQ-1:0]     rvalid_o,
  output logic [31:0]            rdata_o,
  output logic                   sram_ce_o,
  output logic                   sram_we_o,
  output logic [31:0]            sram_addr_o,
  output logic [3:0]             sram_sel_o,
  output logic [31:0]            sram_data_o,
  input  logic [31:0]            sram_data_i
);

  localparam int PW        = $clog2(NUM_REQ);
  localparam int HOLD_LAST = (MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0;
  localparam int HW        = (HOLD_LAST > 0) ? $clog2(HOLD_LAST + 1) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_REQ - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_LAST);
  localparam logic LIMITED = (MAX_HOLD > 0);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [NUM_REQ-1:0]   r_gnt;
  logic [NUM_REQ-1:0]   w_gnt_nxt;
  logic [NUM_REQ-1:0]   r_rvalid;
  logic [PW-1:0]        r_ptr;
  logic [PW-1:0]        w_ptr_nxt;
  logic [HW-1:0]        r_hold;
  logic [HW-1:0]        w_hold_nxt;
  logic [PW-1:0]        w_own;
  logic [PW-1:0]        w_win;
  logic [PW-1:0]        w_scan;
  logic                 w_win_found;
  logic                 w_take;
  logic                 w_other_req;
  logic                 w_limit_hit;
  logic                 w_keep;
  logic                 w_ce;
  logic                 w_we;
  logic [31:0]          w_addr;
  logic [3:0]           w_sel;
  logic [31:0]          w_wdata;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    return (v == PTR_LAST) ? {PW{1'b0}} : (v + 1'b1);
  endfunction

  // Index of the current owner, decoded from the one-hot grant
  always_comb begin
    w_own = {PW{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      w_own = w_own | (r_gnt[k] ? PW'(k) : {PW{1'b0}});
    end
  end

  // Round-robin scan starting at the pointer; first requester found wins
  always_comb begin
    w_win       = {PW{1'b0}};
    w_win_found = 1'b0;
    w_take      = 1'b0;
    w_scan      = r_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_take      = req_i[w_scan] & ~w_win_found;
      w_win       = w_take ? w_scan : w_win;
      w_win_found = w_win_found | req_i[w_scan];
      w_scan      = wrap_inc(w_scan);
    end
  end

  assign w_other_req = |(req_i & ~r_gnt);
  assign w_limit_hit = LIMITED && (r_hold == HOLD_MAX) && w_other_req;
  assign w_keep      = (r_state == ST_OWNED) && req_i[w_own] && lock_i[w_own] && !w_limit_hit;

  // Next grant, pointer and hold count
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_ptr_nxt   = r_ptr;
    w_hold_nxt  = r_hold;
    case (r_state)
      ST_OWNED: begin
        if (w_keep) begin
          w_hold_nxt = (r_hold == HOLD_MAX) ? r_hold : (r_hold + 1'b1);
        end else if (w_win_found) begin
          w_state_nxt = ST_OWNED;
          w_gnt_nxt   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
          w_ptr_nxt   = wrap_inc(w_win);
          w_hold_nxt  = {HW{1'b0}};
        end else begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = {NUM_REQ{1'b0}};
          w_hold_nxt  = {HW{1'b0}};
        end
      end
      ST_IDLE: begin
        if (w_win_found) begin
          w_state_nxt = ST_OWNED;
          w_gnt_nxt   = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_win;
          w_ptr_nxt   = wrap_inc(w_win);
          w_hold_nxt  = {HW{1'b0}};
        end else begin
          w_state_nxt = ST_IDLE;
          w_gnt_nxt   = {NUM_REQ{1'b0}};
          w_hold_nxt  = {HW{1'b0}};
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gnt_nxt   = {NUM_REQ{1'b0}};
        w_ptr_nxt   = {PW{1'b0}};
        w_hold_nxt  = {HW{1'b0}};
      end
    endcase
  end

  // State, grant, pointer, hold counter and read tag registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_gnt    <= {NUM_REQ{1'b0}};
      r_ptr    <= {PW{1'b0}};
      r_hold   <= {HW{1'b0}};
      r_rvalid <= {NUM_REQ{1'b0}};
    end else begin
      r_state  <= w_state_nxt;
      r_gnt    <= w_gnt_nxt;
      r_ptr    <= w_ptr_nxt;
      r_hold   <= w_hold_nxt;
      r_rvalid <= r_gnt & ce_i & ~we_i;
    end
  end

  // AND-OR mux of the granted master onto the SRAM port; all zero when idle
  always_comb begin
    w_addr  = 32'h0000_0000;
    w_sel   = 4'h0;
    w_wdata = 32'h0000_0000;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_addr  = w_addr  | (addr_i[32*k +: 32]  & {32{r_gnt[k]}});
      w_sel   = w_sel   | (sel_i[4*k +: 4]     & {4{r_gnt[k]}});
      w_wdata = w_wdata | (wdata_i[32*k +: 32] & {32{r_gnt[k]}});
    end
  end

  assign w_ce = |(r_gnt & ce_i);
  assign w_we = |(r_gnt & we_i);

  assign gnt_o       = r_gnt;
  assign rvalid_o    = r_rvalid;
  assign rdata_o     = sram_data_i;
  assign sram_ce_o   = w_ce;
  assign sram_we_o   = w_we;
  assign sram_addr_o = w_addr;
  assign sram_sel_o  = w_sel;
  assign sram_data_o = w_wdata;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios then random traffic,
// compared every cycle against an integer-level reference model and a reference memory.
module tb_sram_arbiter;

  localparam int N  = 4;
  localparam int MH = 6;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_i, lock_i, ce_i, we_i;
  logic [N*32-1:0] addr_i, wdata_i;
  logic [N*4-1:0]  sel_i;
  logic [N-1:0]    gnt_o, rvalid_o;
  logic [31:0]     rdata_o;
  logic            sram_ce_o, sram_we_o;
  logic [31:0]     sram_addr_o, sram_data_o;
  logic [3:0]      sram_sel_o;
  logic [31:0]     sram_data_i = 32'h0;

  always #5 clk = ~clk;

  sram_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .lock_i(lock_i), .ce_i(ce_i), .we_i(we_i),
    .addr_i(addr_i), .sel_i(sel_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .sram_ce_o(sram_ce_o), .sram_we_o(sram_we_o),
    .sram_addr_o(sram_addr_o), .sram_sel_o(sram_sel_o), .sram_data_o(sram_data_o),
    .sram_data_i(sram_data_i)
  );

  function automatic logic [31:0] mem_init(input int i);
    return 32'(i) * 32'h9E37_79B9 + 32'h0BAD_F00D;
  endfunction

  // SRAM behavioural memory, reloaded while reset is held
  logic [31:0] mem [0:255];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= mem_init(i);
    end else if (sram_ce_o) begin
      if (sram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (sram_sel_o[b]) mem[sram_addr_o[9:2]][8*b +: 8] <= sram_data_o[8*b +: 8];
      end else begin
        sram_data_i <= mem[sram_addr_o[9:2]];
      end
    end
  end

  // Reference model state
  int          m_own, m_ptr, m_hold;
  logic [N-1:0] m_rvalid;
  logic [31:0] m_rdata;
  logic [31:0] ref_mem [0:255];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_hold = 0; m_rvalid = '0; m_rdata = 32'h0;
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(i);
  endtask

  // Advance the model across one rising edge using the inputs currently driven
  task automatic model_step();
    int   nown, nptr, nhold;
    logic others;
    logic [7:0] wi;
    nown = -1; nptr = m_ptr; nhold = 0; others = 1'b0;
    m_rvalid = '0;
    if (m_own >= 0 && ce_i[m_own]) begin
      wi = addr_i[32*m_own+2 +: 8];
      if (we_i[m_own]) begin
        for (int b = 0; b < 4; b++)
          if (sel_i[4*m_own+b]) ref_mem[wi][8*b +: 8] = wdata_i[32*m_own+8*b +: 8];
      end else begin
        m_rvalid[m_own] = 1'b1;
        m_rdata = ref_mem[wi];
      end
    end
    for (int k = 0; k < N; k++) if (k != m_own && req_i[k]) others = 1'b1;
    if (m_own >= 0 && req_i[m_own] && lock_i[m_own] &&
        !(MH != 0 && m_hold == MH - 1 && others)) begin
      nown  = m_own;
      nhold = (m_hold < MH - 1) ? m_hold + 1 : m_hold;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (nown < 0 && req_i[(m_ptr + i) % N]) begin
          nown = (m_ptr + i) % N;
          nptr = (nown + 1) % N;
        end
      end
    end
    m_own = nown; m_ptr = nptr; m_hold = nhold;
  endtask

  task automatic check_outputs(input string tag);
    logic [N-1:0] eg;
    logic [37:0]  eport;
    logic [31:0]  edata;
    eg = (m_own >= 0) ? (N'(1) << m_own) : '0;
    eport = '0; edata = 32'h0;
    if (m_own >= 0) begin
      eport = {ce_i[m_own], we_i[m_own], sel_i[4*m_own +: 4], addr_i[32*m_own +: 32]};
      edata = wdata_i[32*m_own +: 32];
    end
    check_eq({tag, " gnt"}, 64'(gnt_o), 64'(eg));
    check_eq({tag, " rvalid"}, 64'(rvalid_o), 64'(m_rvalid));
    if (m_rvalid != '0) check_eq({tag, " rdata"}, 64'(rdata_o), 64'(m_rdata));
    check_eq({tag, " port"}, 64'({sram_ce_o, sram_we_o, sram_sel_o, sram_addr_o}), 64'(eport));
    check_eq({tag, " wdata"}, 64'(sram_data_o), 64'(edata));
  endtask

  // Called at a falling edge: drive, model, clock, check at next falling edge
  task automatic tick(input string tag, input logic [N-1:0] rq, input logic [N-1:0] lk,
                      input logic [N-1:0] c, input logic [N-1:0] w);
    req_i = rq; lock_i = lk; ce_i = c; we_i = w;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic rand_bus();
    for (int k = 0; k < N; k++) begin
      addr_i[32*k +: 32]  = {22'd0, 8'($urandom), 2'b00};
      sel_i[4*k +: 4]     = 4'($urandom);
      wdata_i[32*k +: 32] = $urandom;
    end
  endtask

  logic [3:0]   seq [4];
  logic [N-1:0] r_req, r_lock;
  int           cnt;

  initial begin
    seq[0] = 4'b0010; seq[1] = 4'b0100; seq[2] = 4'b1000; seq[3] = 4'b0001;
    rst = 1'b0;
    req_i = 4'b1111; lock_i = '0; ce_i = '0; we_i = '0;
    addr_i = '0; sel_i = '0; wdata_i = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_eq("t1 reset gnt", 64'(gnt_o), 64'(4'b0000));
    check_eq("t1 reset ce", 64'(sram_ce_o), 64'(1'b0));
    check_eq("t1 reset rvalid", 64'(rvalid_o), 64'(4'b0000));
    rst = 1'b1;
    tick("t1", 4'b1111, 4'b0000, 4'b0000, 4'b0000);
    check_eq("t1 first gnt", 64'(gnt_o), 64'(4'b0001));

    for (int i = 0; i < 4; i++) begin
      tick("t2", 4'b1111, 4'b0000, 4'b0000, 4'b0000);
      check_eq("t2 rr seq", 64'(gnt_o), 64'(seq[i]));
    end

    tick("t3 idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick("t3", 4'b0110, 4'b0010, 4'b0000, 4'b0000);
      if (gnt_o == 4'b0010) cnt++;
    end
    check_eq("t3 lock cycles", 64'(cnt), 64'(5));
    tick("t3 hand", 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    check_eq("t3 handover", 64'(gnt_o), 64'(4'b0100));

    tick("t4 idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick("t4", 4'b0001, 4'b0001, 4'b0000, 4'b0000);
    cnt = (gnt_o == 4'b0001) ? 1 : 0;
    for (int i = 0; i < 2 * MH; i++) begin
      if (gnt_o == 4'b0001) begin
        tick("t4", 4'b1001, 4'b0001, 4'b0000, 4'b0000);
        if (gnt_o == 4'b0001) cnt++;
      end
    end
    check_eq("t4 hold limit", 64'(cnt), 64'(MH));
    check_eq("t4 after limit", 64'(gnt_o), 64'(4'b1000));

    tick("t5 idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    tick("t5", 4'b0100, 4'b0100, 4'b0000, 4'b0000);
    addr_i[64 +: 32] = 32'h0000_0040;
    tick("t5", 4'b0100, 4'b0100, 4'b0100, 4'b0000);
    check_eq("t5 rvalid", 64'(rvalid_o), 64'(4'b0100));
    check_eq("t5 rdata", 64'(rdata_o), 64'(mem_init(16)));

    tick("t6", 4'b0100, 4'b0100, 4'b0100, 4'b0000);
    check_eq("t6 pre rvalid", 64'(rvalid_o), 64'(4'b0100));
    rst = 1'b0;
    #1;
    check_eq("t6 async gnt", 64'(gnt_o), 64'(4'b0000));
    check_eq("t6 async rvalid", 64'(rvalid_o), 64'(4'b0000));
    check_eq("t6 async ce", 64'(sram_ce_o), 64'(1'b0));
    model_reset();
    @(negedge clk);
    rst = 1'b1;

    r_req = '0; r_lock = '0;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) == 0) r_req[k] = ~r_req[k];
        if ($urandom_range(0, 5) == 0) r_lock[k] = ~r_lock[k];
      end
      rand_bus();
      tick("rand", r_req, r_lock, N'($urandom), N'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
